issue_queue: RTL and testbench

- Unified scheduler between rename_stage and the functional units.
- Buffers renamed instructions and tracks operand readiness from FU PRN-ready broadcasts.
- Each cycle, selects the oldest ready instruction per FU whose fu_ready is high and presents it on a registered issue port. Operand read from prf happens downstream.
- Decides when the shared FU/PRF read-port datapath is used, and by which instruction.

---
 rtl/foxtrot_pkg.sv | 34 +++
 rtl/iq_age_select.sv | 23 ++
 rtl/issue_queue.sv | 217 +++++++++++++++++++++
 tb/tb_issue_queue.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/foxtrot_pkg.sv
// rtl/foxtrot_pkg.sv - shared constants and entry/issue types for the issue queue
package foxtrot_pkg;

  localparam int MAX_OPERANDS = 3;
  localparam int PRN_BITS     = 6;
  localparam int INST_ID_BITS = 6;
  localparam int FU_COUNT     = 4;
  localparam int FU_BITS      = $clog2(FU_COUNT);

  typedef struct packed {
    logic                                   valid;
    logic [INST_ID_BITS-1:0]                inst_id;
    logic [31:0]                            raw_instr;
    logic [63:0]                            pc;
    logic [FU_BITS-1:0]                     fu;
    logic [MAX_OPERANDS-1:0]                src_valid;
    logic [MAX_OPERANDS-1:0]                src_ready;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  src_prn;
    logic [MAX_OPERANDS-1:0]                dst_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  dst_prn;
  } iq_entry_t;

  typedef struct packed {
    logic                                   valid;
    logic [INST_ID_BITS-1:0]                inst_id;
    logic [31:0]                            raw_instr;
    logic [63:0]                            pc;
    logic [MAX_OPERANDS-1:0]                src_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  src_prn;
    logic [MAX_OPERANDS-1:0]                dst_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  dst_prn;
  } issue_pkt_t;

endpackage

// File: rtl/iq_age_select.sv
// rtl/iq_age_select.sv - picks the oldest candidate from a shared age matrix
module iq_age_select #(
  parameter int ENTRIES = 8
) (
  input  logic [ENTRIES-1:0][ENTRIES-1:0] older,
  input  logic [ENTRIES-1:0]              cand,
  output logic [ENTRIES-1:0]              grant
);

  // A candidate wins when no other candidate is older than it; the age
  // matrix is a strict order over live entries, so at most one wins.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      grant[i] = cand[i];
      for (int j = 0; j < ENTRIES; j++) begin
        if (cand[j] && older[j][i]) begin
          grant[i] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - unified scheduler: buffers renamed ops, wakes sources, issues oldest ready per FU
module issue_queue
  import foxtrot_pkg::*;
#(
  parameter int ENTRIES    = 8,
  parameter int WAKE_PORTS = 3
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 disp_valid,
  output logic                                                 disp_ready,
  input  logic [INST_ID_BITS-1:0]                              disp_inst_id,
  input  logic [31:0]                                          disp_raw_instr,
  input  logic [63:0]                                          disp_pc,
  input  logic [FU_BITS-1:0]                                   disp_fu,
  input  logic [MAX_OPERANDS-1:0]                              disp_src_valid,
  input  logic [MAX_OPERANDS-1:0]                              disp_src_ready,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]                disp_src_prn,
  input  logic [MAX_OPERANDS-1:0]                              disp_dst_valid,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]                disp_dst_prn,
  input  logic [WAKE_PORTS-1:0]                                wake_valid,
  input  logic [WAKE_PORTS-1:0][PRN_BITS-1:0]                  wake_prn,
  input  logic [FU_COUNT-1:0]                                  fu_ready,
  output logic [FU_COUNT-1:0]                                  issue_valid,
  output logic [FU_COUNT-1:0][INST_ID_BITS-1:0]                issue_inst_id,
  output logic [FU_COUNT-1:0][31:0]                            issue_raw_instr,
  output logic [FU_COUNT-1:0][63:0]                            issue_pc,
  output logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]                issue_src_valid,
  output logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]  issue_src_prn,
  output logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]                issue_dst_valid,
  output logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]  issue_dst_prn,
  input  logic                                                 flush,
  output logic [$clog2(ENTRIES):0]                             occupancy
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int OCC_BITS = IDX_BITS + 1;

  iq_entry_t                      ent_q [ENTRIES];
  logic [ENTRIES-1:0][ENTRIES-1:0] older_q;
  logic [OCC_BITS-1:0]            occ_q;
  issue_pkt_t                     iss_q [FU_COUNT];
  issue_pkt_t                     iss_d [FU_COUNT];

  logic [ENTRIES-1:0][MAX_OPERANDS-1:0] src_hit;
  logic [MAX_OPERANDS-1:0]              disp_hit;
  logic [IDX_BITS-1:0]                  free_idx;
  logic                                 disp_fire;
  iq_entry_t                            new_ent;
  logic [ENTRIES-1:0]                   cand  [FU_COUNT];
  logic [ENTRIES-1:0]                   grant [FU_COUNT];
  logic [ENTRIES-1:0]                   freed;
  logic [OCC_BITS-1:0]                  issue_cnt;

  // Ready-to-accept looks only at registered occupancy so select cannot
  // feed back into the renamer handshake within a cycle.
  assign occupancy  = occ_q;
  assign disp_ready = (occ_q < OCC_BITS'(ENTRIES)) && !flush;
  assign disp_fire  = disp_valid && disp_ready;

  // Match every stored and incoming source PRN against the wake ports.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      for (int s = 0; s < MAX_OPERANDS; s++) begin
        src_hit[i][s] = 1'b0;
        for (int p = 0; p < WAKE_PORTS; p++) begin
          if (wake_valid[p] && (wake_prn[p] == ent_q[i].src_prn[s])) begin
            src_hit[i][s] = 1'b1;
          end
        end
      end
    end
    for (int s = 0; s < MAX_OPERANDS; s++) begin
      disp_hit[s] = 1'b0;
      for (int p = 0; p < WAKE_PORTS; p++) begin
        if (wake_valid[p] && (wake_prn[p] == disp_src_prn[s])) begin
          disp_hit[s] = 1'b1;
        end
      end
    end
  end

  // Lowest-index free slot and the entry image written there on dispatch.
  always_comb begin
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!ent_q[i].valid) begin
        free_idx = IDX_BITS'(i);
      end
    end
    new_ent.valid     = 1'b1;
    new_ent.inst_id   = disp_inst_id;
    new_ent.raw_instr = disp_raw_instr;
    new_ent.pc        = disp_pc;
    new_ent.fu        = disp_fu;
    new_ent.src_valid = disp_src_valid;
    new_ent.src_ready = ~disp_src_valid | disp_src_ready | disp_hit;
    new_ent.src_prn   = disp_src_prn;
    new_ent.dst_valid = disp_dst_valid;
    new_ent.dst_prn   = disp_dst_prn;
  end

  // Per-FU candidates use registered ready bits only.
  always_comb begin
    for (int f = 0; f < FU_COUNT; f++) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cand[f][i] = fu_ready[f] && ent_q[i].valid &&
                     (ent_q[i].fu == FU_BITS'(f)) && (&ent_q[i].src_ready);
      end
    end
  end

  for (genvar f = 0; f < FU_COUNT; f++) begin : g_sel
    iq_age_select #(
      .ENTRIES (ENTRIES)
    ) u_age_select (
      .older (older_q),
      .cand  (cand[f]),
      .grant (grant[f])
    );
  end

  // Mux each FU's winner onto its next issue packet and mark the slot freed;
  // an idle port keeps its last payload with valid dropped.
  always_comb begin
    freed     = '0;
    issue_cnt = '0;
    for (int f = 0; f < FU_COUNT; f++) begin
      iss_d[f]       = iss_q[f];
      iss_d[f].valid = 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        if (grant[f][i]) begin
          iss_d[f].valid     = 1'b1;
          iss_d[f].inst_id   = ent_q[i].inst_id;
          iss_d[f].raw_instr = ent_q[i].raw_instr;
          iss_d[f].pc        = ent_q[i].pc;
          iss_d[f].src_valid = ent_q[i].src_valid;
          iss_d[f].src_prn   = ent_q[i].src_prn;
          iss_d[f].dst_valid = ent_q[i].dst_valid;
          iss_d[f].dst_prn   = ent_q[i].dst_prn;
          freed[i]           = 1'b1;
          issue_cnt          = issue_cnt + OCC_BITS'(1);
        end
      end
    end
  end

  // Entry storage: wakeups set ready bits, select frees, dispatch writes.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ent_q[i].valid <= 1'b0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        for (int s = 0; s < MAX_OPERANDS; s++) begin
          if (src_hit[i][s]) begin
            ent_q[i].src_ready[s] <= 1'b1;
          end
        end
        if (freed[i]) begin
          ent_q[i].valid <= 1'b0;
        end
      end
      if (disp_fire) begin
        ent_q[free_idx] <= new_ent;
      end
    end
  end

  // Age matrix: a new entry is younger than everything currently live.
  always_ff @(posedge clk) begin
    if (rst) begin
      older_q <= '0;
    end else if (!flush && disp_fire) begin
      for (int j = 0; j < ENTRIES; j++) begin
        older_q[free_idx][j] <= 1'b0;
        older_q[j][free_idx] <= ent_q[j].valid;
      end
    end
  end

  // Occupancy and registered issue ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
      for (int f = 0; f < FU_COUNT; f++) begin
        iss_q[f] <= '0;
      end
    end else if (flush) begin
      occ_q <= '0;
      for (int f = 0; f < FU_COUNT; f++) begin
        iss_q[f].valid <= 1'b0;
      end
    end else begin
      occ_q <= occ_q + OCC_BITS'(disp_fire) - issue_cnt;
      for (int f = 0; f < FU_COUNT; f++) begin
        iss_q[f] <= iss_d[f];
      end
    end
  end

  // Flatten issue packets onto the per-FU output ports.
  always_comb begin
    for (int f = 0; f < FU_COUNT; f++) begin
      issue_valid[f]     = iss_q[f].valid;
      issue_inst_id[f]   = iss_q[f].inst_id;
      issue_raw_instr[f] = iss_q[f].raw_instr;
      issue_pc[f]        = iss_q[f].pc;
      issue_src_valid[f] = iss_q[f].src_valid;
      issue_src_prn[f]   = iss_q[f].src_prn;
      issue_dst_valid[f] = iss_q[f].dst_valid;
      issue_dst_prn[f]   = iss_q[f].dst_prn;
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - self-checking bench for issue_queue: vector table, corner sequences, random vs queue model
module tb_issue_queue;
  import foxtrot_pkg::*;

  localparam int ENTRIES    = 8;
  localparam int WAKE_PORTS = 3;

  logic                                                 clk;
  logic                                                 rst;
  logic                                                 disp_valid;
  logic                                                 disp_ready;
  logic [INST_ID_BITS-1:0]                              disp_inst_id;
  logic [31:0]                                          disp_raw_instr;
  logic [63:0]                                          disp_pc;
  logic [FU_BITS-1:0]                                   disp_fu;
  logic [MAX_OPERANDS-1:0]                              disp_src_valid;
  logic [MAX_OPERANDS-1:0]                              disp_src_ready;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]                disp_src_prn;
  logic [MAX_OPERANDS-1:0]                              disp_dst_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]                disp_dst_prn;
  logic [WAKE_PORTS-1:0]                                wake_valid;
  logic [WAKE_PORTS-1:0][PRN_BITS-1:0]                  wake_prn;
  logic [FU_COUNT-1:0]                                  fu_ready;
  logic [FU_COUNT-1:0]                                  issue_valid;
  logic [FU_COUNT-1:0][INST_ID_BITS-1:0]                issue_inst_id;
  logic [FU_COUNT-1:0][31:0]                            issue_raw_instr;
  logic [FU_COUNT-1:0][63:0]                            issue_pc;
  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]                issue_src_valid;
  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]  issue_src_prn;
  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]                issue_dst_valid;
  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]  issue_dst_prn;
  logic                                                 flush;
  logic [3:0]                                           occupancy;

  issue_queue #(
    .ENTRIES    (ENTRIES),
    .WAKE_PORTS (WAKE_PORTS)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .disp_valid      (disp_valid),
    .disp_ready      (disp_ready),
    .disp_inst_id    (disp_inst_id),
    .disp_raw_instr  (disp_raw_instr),
    .disp_pc         (disp_pc),
    .disp_fu         (disp_fu),
    .disp_src_valid  (disp_src_valid),
    .disp_src_ready  (disp_src_ready),
    .disp_src_prn    (disp_src_prn),
    .disp_dst_valid  (disp_dst_valid),
    .disp_dst_prn    (disp_dst_prn),
    .wake_valid      (wake_valid),
    .wake_prn        (wake_prn),
    .fu_ready        (fu_ready),
    .issue_valid     (issue_valid),
    .issue_inst_id   (issue_inst_id),
    .issue_raw_instr (issue_raw_instr),
    .issue_pc        (issue_pc),
    .issue_src_valid (issue_src_valid),
    .issue_src_prn   (issue_src_prn),
    .issue_dst_valid (issue_dst_valid),
    .issue_dst_prn   (issue_dst_prn),
    .flush           (flush),
    .occupancy       (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       dv;
    logic [5:0] id;
    logic [1:0] fu;
    logic [2:0] sv;
    logic [2:0] sr;
    logic [5:0] prn;
    logic       wv;
    logic [5:0] wprn;
    logic [3:0] fr;
    logic       e_dr;
    int         e_occ;
    logic [3:0] e_iv;
    logic [5:0] e_id;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic dv, logic [5:0] id, logic [1:0] fu, logic [2:0] sv,
                              logic [2:0] sr, logic [5:0] prn, logic wv, logic [5:0] wprn,
                              logic [3:0] fr, logic e_dr, int e_occ, logic [3:0] e_iv,
                              logic [5:0] e_id);
    vec_t v;
    v.dv = dv; v.id = id; v.fu = fu; v.sv = sv; v.sr = sr; v.prn = prn;
    v.wv = wv; v.wprn = wprn; v.fr = fr;
    v.e_dr = e_dr; v.e_occ = e_occ; v.e_iv = e_iv; v.e_id = e_id;
    return v;
  endfunction

  task automatic idle_inputs();
    disp_valid     = 1'b0;
    disp_inst_id   = '0;
    disp_raw_instr = '0;
    disp_pc        = '0;
    disp_fu        = '0;
    disp_src_valid = '0;
    disp_src_ready = '0;
    disp_src_prn   = '0;
    disp_dst_valid = '0;
    disp_dst_prn   = '0;
    wake_valid     = '0;
    wake_prn       = '0;
    fu_ready       = '1;
    flush          = 1'b0;
  endtask

  task automatic drive_disp(input logic dv, input logic [5:0] id, input logic [1:0] fu,
                            input logic [2:0] sv, input logic [2:0] sr, input logic [5:0] prn);
    disp_valid     = dv;
    disp_inst_id   = id;
    disp_raw_instr = 32'hA000_0000 | 32'(id);
    disp_pc        = 64'h1000 + 64'(id) * 4;
    disp_fu        = fu;
    disp_src_valid = sv;
    disp_src_ready = sr;
    disp_src_prn   = {6'(prn + 6'd2), 6'(prn + 6'd1), prn};
    disp_dst_valid = 3'b001;
    disp_dst_prn   = {12'h0, 6'(id + 6'd32)};
  endtask

  // Reference model: age-ordered queue of live instructions.
  typedef struct {
    logic [5:0]  id;
    logic [31:0] raw;
    logic [63:0] pc;
    logic [1:0]  fu;
    logic [2:0]  sv;
    logic [2:0]  sr;
    logic [17:0] sp;
    logic [2:0]  dv;
    logic [17:0] dp;
  } m_ent_t;

  m_ent_t       mq[$];
  logic [3:0]   m_iv;
  logic [143:0] m_pay [4];

  function automatic logic woke(input logic [5:0] prn);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WAKE_PORTS; p++) begin
      if (wake_valid[p] && wake_prn[p] == prn) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [143:0] dut_pay(input int f);
    return {issue_inst_id[f], issue_raw_instr[f], issue_pc[f], issue_src_valid[f],
            issue_src_prn[f], issue_dst_valid[f], issue_dst_prn[f]};
  endfunction

  task automatic model_edge();
    m_ent_t e;
    logic   fire;
    if (flush) begin
      mq.delete();
      m_iv = '0;
    end else begin
      fire = disp_valid && (mq.size() < ENTRIES);
      m_iv = '0;
      for (int f = 0; f < FU_COUNT; f++) begin
        if (fu_ready[f]) begin
          for (int k = 0; k < mq.size(); k++) begin
            if (int'(mq[k].fu) == f && mq[k].sr == 3'b111) begin
              m_iv[f]  = 1'b1;
              m_pay[f] = {mq[k].id, mq[k].raw, mq[k].pc, mq[k].sv, mq[k].sp, mq[k].dv, mq[k].dp};
              mq.delete(k);
              break;
            end
          end
        end
      end
      for (int k = 0; k < mq.size(); k++) begin
        for (int s = 0; s < 3; s++) begin
          if (woke(mq[k].sp[s*6 +: 6])) mq[k].sr[s] = 1'b1;
        end
      end
      if (fire) begin
        e.id = disp_inst_id; e.raw = disp_raw_instr; e.pc = disp_pc; e.fu = disp_fu;
        e.sv = disp_src_valid; e.sp = disp_src_prn; e.dv = disp_dst_valid; e.dp = disp_dst_prn;
        for (int s = 0; s < 3; s++) begin
          e.sr[s] = !disp_src_valid[s] || disp_src_ready[s] || woke(disp_src_prn[s]);
        end
        mq.push_back(e);
      end
    end
  endtask

  initial begin
    int fidx;
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_occ", 144'(occupancy), 144'(0));
    check("reset_iv", 144'(issue_valid), 144'(0));
    check("reset_dr", 144'(disp_ready), 144'(1));
    check("reset_pay", 144'(dut_pay(1)), 144'(0));

    // Basic issue, late wakeup, in-order drain, same-cycle wake bypass.
    vt.push_back(mk(1, 5, 1, 7, 7, 0, 0, 0, 4'hF, 1, 0, 4'h0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 1, 1, 4'h0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 1, 0, 4'h2, 5));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 1, 0, 4'h0, 0));
    vt.push_back(mk(1, 3, 2, 1, 0, 12, 0, 0, 4'hF, 1, 0, 4'h0, 0));
    for (int i = 0; i < 4; i++) vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 1, 1, 4'h0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 12, 4'hF, 1, 1, 4'h0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 1, 1, 4'h0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 1, 0, 4'h4, 3));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 1, 0, 4'h0, 0));
    vt.push_back(mk(1, 10, 0, 7, 7, 0, 0, 0, 4'hE, 1, 0, 4'h0, 0));
    vt.push_back(mk(1, 11, 0, 7, 7, 0, 0, 0, 4'hE, 1, 1, 4'h0, 0));
    vt.push_back(mk(1, 12, 0, 7, 7, 0, 0, 0, 4'hE, 1, 2, 4'h0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 1, 3, 4'h0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 1, 2, 4'h1, 10));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 1, 1, 4'h1, 11));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 1, 0, 4'h1, 12));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 1, 0, 4'h0, 0));
    vt.push_back(mk(1, 7, 3, 1, 0, 20, 1, 20, 4'hF, 1, 0, 4'h0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 1, 1, 4'h0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 1, 0, 4'h8, 7));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 1, 0, 4'h0, 0));

    for (int r = 0; r < vt.size(); r++) begin
      @(negedge clk);
      idle_inputs();
      drive_disp(vt[r].dv, vt[r].id, vt[r].fu, vt[r].sv, vt[r].sr, vt[r].prn);
      wake_valid  = {2'b00, vt[r].wv};
      wake_prn[0] = vt[r].wprn;
      fu_ready    = vt[r].fr;
      #1;
      check($sformatf("vec%0d_dr", r), 144'(disp_ready), 144'(vt[r].e_dr));
      check($sformatf("vec%0d_occ", r), 144'(occupancy), 144'(vt[r].e_occ));
      check($sformatf("vec%0d_iv", r), 144'(issue_valid), 144'(vt[r].e_iv));
      if (vt[r].e_iv != 4'h0) begin
        fidx = 0;
        for (int f = FU_COUNT - 1; f >= 0; f--) if (vt[r].e_iv[f]) fidx = f;
        check($sformatf("vec%0d_id", r), 144'(issue_inst_id[fidx]), 144'(vt[r].e_id));
      end
    end

    // Fill all slots with waiting ops, refuse a ninth, then free one by wakeup.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle_inputs();
      drive_disp(1'b1, 6'(20 + i), 2'(i % 4), 3'b001, 3'b000, 6'(40 + i));
      #1;
      check("full_fill_dr", 144'(disp_ready), 144'(1));
    end
    @(negedge clk);
    idle_inputs();
    drive_disp(1'b1, 6'd28, 2'd0, 3'b000, 3'b000, 6'd0);
    #1;
    check("full_occ", 144'(occupancy), 144'(8));
    check("full_dr", 144'(disp_ready), 144'(0));
    @(negedge clk);
    idle_inputs();
    wake_valid[1] = 1'b1;
    wake_prn[1]   = 6'd43;
    #1;
    check("full_ninth_rejected", 144'(occupancy), 144'(8));
    @(negedge clk);
    idle_inputs();
    #1;
    check("full_no_early_issue", 144'(issue_valid), 144'(0));
    @(negedge clk);
    #1;
    check("full_issue_iv", 144'(issue_valid), 144'(4'b1000));
    check("full_issue_id", 144'(issue_inst_id[3]), 144'(23));
    check("full_after_occ", 144'(occupancy), 144'(7));
    check("full_after_dr", 144'(disp_ready), 144'(1));

    // Mid-run reset discards the remaining waiting entries.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_occ", 144'(occupancy), 144'(0));
    check("midrst_dr", 144'(disp_ready), 144'(1));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      idle_inputs();
      wake_valid = 3'b111;
      wake_prn   = {6'(42 + 3 * c), 6'(41 + 3 * c), 6'(40 + 3 * c)};
      #1;
      check("midrst_no_issue", 144'(issue_valid), 144'(0));
    end

    // Flush with a held queue and a simultaneous dispatch.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_inputs();
      fu_ready = 4'h0;
      drive_disp(1'b1, 6'(30 + i), 2'(i), 3'b111, 3'b111, 6'd1);
    end
    @(negedge clk);
    idle_inputs();
    drive_disp(1'b1, 6'd50, 2'd0, 3'b111, 3'b111, 6'd1);
    flush = 1'b1;
    #1;
    check("flush_occ_before", 144'(occupancy), 144'(4));
    check("flush_dr", 144'(disp_ready), 144'(0));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      check("flush_occ", 144'(occupancy), 144'(0));
      check("flush_iv", 144'(issue_valid), 144'(0));
    end

    // Randomized run against the queue model.
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_iv = '0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      disp_valid     = ($urandom_range(0, 9) < 6);
      disp_inst_id   = 6'($urandom);
      disp_raw_instr = $urandom;
      disp_pc        = {$urandom, $urandom};
      disp_fu        = 2'($urandom_range(0, 3));
      disp_src_valid = 3'($urandom);
      disp_dst_valid = 3'($urandom);
      for (int s = 0; s < 3; s++) begin
        disp_src_ready[s] = ($urandom_range(0, 3) == 0);
        disp_src_prn[s]   = 6'($urandom_range(0, 15));
        disp_dst_prn[s]   = 6'($urandom);
      end
      for (int p = 0; p < WAKE_PORTS; p++) begin
        wake_valid[p] = ($urandom_range(0, 2) == 0);
        wake_prn[p]   = 6'($urandom_range(0, 15));
      end
      for (int f = 0; f < FU_COUNT; f++) fu_ready[f] = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 49) == 0);
      #1;
      check("rnd_occ", 144'(occupancy), 144'(mq.size()));
      check("rnd_dr", 144'(disp_ready), 144'((mq.size() < ENTRIES) && !flush));
      for (int f = 0; f < FU_COUNT; f++) begin
        check($sformatf("rnd_iv%0d", f), 144'(issue_valid[f]), 144'(m_iv[f]));
        if (m_iv[f]) check($sformatf("rnd_pay%0d", f), dut_pay(f), m_pay[f]);
      end
      model_edge();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
